// File: rtl/divider16x8.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per cycle.
// Start/done handshake; divide-by-zero short-circuits the iteration and raises DZ.
module divider16x8 #(
    parameter int unsigned DW = 16,
    parameter int unsigned VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] P,
    input  logic [VW-1:0] B,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] Q,
    output logic [VW-1:0] R,
    output logic          DZ
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] quo;
    logic [VW:0]   rem;
    logic [VW-1:0] div;
    logic          dz_op;
    logic          finish_c;
    logic [VW:0]   shifted_c;
    logic [VW:0]   diff_c;
    logic          ge_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE holds an extra cycle only for a zero divisor (cnt preloaded to 1)
    always_comb begin
        state_nxt = state;
        finish_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (B == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(DW - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (cnt == '0) begin
                    finish_c  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shifted_c = {rem[VW-1:0], quo[DW-1]};
        diff_c    = shifted_c - {1'b0, div};
        ge_c      = (shifted_c >= {1'b0, div});
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            div   <= '0;
            dz_op <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b0;
            Q     <= '0;
            R     <= '0;
            DZ    <= 1'b0;
        end else begin
            ready <= (state_nxt == IDLE);
            done  <= finish_c;
            case (state)
                IDLE: begin
                    if (start) begin
                        quo   <= P;
                        div   <= B;
                        rem   <= '0;
                        dz_op <= (B == '0);
                        cnt   <= (B == '0) ? CW'(1) : '0;
                    end
                end
                CALC: begin
                    quo <= {quo[DW-2:0], ge_c};
                    rem <= ge_c ? diff_c : shifted_c;
                    cnt <= (cnt == CW'(DW - 1)) ? '0 : CW'(cnt + 1'b1);
                end
                DONE: begin
                    if (cnt != '0) begin
                        cnt <= CW'(cnt - 1'b1);
                    end else begin
                        Q  <= dz_op ? '1 : quo;
                        R  <= dz_op ? '0 : rem[VW-1:0];
                        DZ <= dz_op;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider16x8.sv
// Scoreboard bench for divider16x8: stimulus pushes expected results, a negedge monitor
// pops and compares them (value and latency) whenever done is seen.
module tb_divider16x8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] P;
    logic [7:0]  B;
    logic        ready;
    logic        done;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        DZ;

    divider16x8 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .P     (P),
        .B     (B),
        .ready (ready),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .DZ    (DZ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          t;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Wait for ready, then present one request; optionally record its expected result
    task automatic issue(input logic [15:0] p, input logic [7:0] b, input logic [15:0] q,
                         input logic [7:0] r, input logic dz, input bit track);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", 32'(ready), 32'd1);
        P     = p;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (track) sb.push_back('{q, r, dz, cyc + ((b == 8'd0) ? 2 : 17)});
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", 32'(Q), 32'(e.q));
                chk("remainder", 32'(R), 32'(e.r));
                chk("dz_flag", 32'(DZ), 32'(e.dz));
                chk("latency", 32'(cyc), 32'(e.t));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          a1;
        int          d0;
        bit          low_ok;
        logic [15:0] rp;
        logic [7:0]  rb;
        logic [7:0]  ra;

        rst   = 1'b1;
        start = 1'b0;
        P     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_q", 32'(Q), 32'd0);
        chk("reset_r", 32'(R), 32'd0);
        chk("reset_dz", 32'(DZ), 32'd0);
        rst = 1'b0;

        // First op, ready must stay low through CALC and DONE
        issue(16'h000F, 8'h03, 16'h0005, 8'h00, 1'b0, 1'b1);
        low_ok = 1'b1;
        repeat (17) begin
            @(negedge clk);
            if (ready) low_ok = 1'b0;
        end
        chk("ready_low_busy", 32'(low_ok), 32'd1);
        wait_idle();

        issue(16'h0064, 8'h07, 16'h000E, 8'h02, 1'b0, 1'b1);
        issue(16'h1234, 8'h10, 16'h0123, 8'h04, 1'b0, 1'b1);
        issue(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 1'b1);
        issue(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 1'b1);
        issue(16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 1'b1);

        // Divide by zero, then DZ cleared by a normal op
        issue(16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1, 1'b1);
        issue(16'h0006, 8'h02, 16'h0003, 8'h00, 1'b0, 1'b1);
        wait_idle();

        // Start during CALC is ignored: one done, first result intact
        d0 = done_cnt;
        issue(16'h03E8, 8'h0A, 16'h0064, 8'h00, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        P     = 16'hFFFF;
        B     = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("single_done", 32'(done_cnt - d0), 32'd1);

        // Back-to-back: second start in the IDLE cycle right after DONE
        issue(16'h00C8, 8'h0B, 16'h0012, 8'h02, 1'b0, 1'b1);
        a1 = last_acc;
        issue(16'h0007, 8'h03, 16'h0002, 8'h01, 1'b0, 1'b1);
        chk("issue_interval", 32'(last_acc - a1), 32'd18);
        wait_idle();

        // Reset in the middle of an op: drop it, no done, outputs cleared
        d0 = done_cnt;
        issue(16'hABCD, 8'h0C, 16'h0000, 8'h00, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_q", 32'(Q), 32'd0);
        chk("midrst_r", 32'(R), 32'd0);
        repeat (20) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        issue(16'h00FF, 8'h10, 16'h000F, 8'h0F, 1'b0, 1'b1);
        wait_idle();

        // Random sweep with nonzero divisor
        for (int i = 0; i < 900; i++) begin
            rp = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(1, 255));
            issue(rp, rb, rp / 16'(rb), 8'(rp % 16'(rb)), 1'b0, 1'b1);
        end
        // Multiplier round trip: (A*B)/B == A, remainder 0
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            rp = 16'(ra) * 16'(rb);
            issue(rp, rb, 16'(ra), 8'h00, 1'b0, 1'b1);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
